// File: rtl/vpg_multi.sv
// vpg_multi: programmable video timing generator with eight test patterns.
// Latency 3 clocks from counter state to outputs; free-running, no backpressure.
module vpg_multi #(
  parameter int CW = 12,
  parameter int DW = 8,
  parameter int GL = 5
) (
  input  logic          I_pxl_clk,
  input  logic          I_rst_n,
  input  logic [2:0]    I_mode,
  input  logic [DW-1:0] I_single_r,
  input  logic [DW-1:0] I_single_g,
  input  logic [DW-1:0] I_single_b,
  input  logic [CW-1:0] I_h_total,
  input  logic [CW-1:0] I_h_sync,
  input  logic [CW-1:0] I_h_bporch,
  input  logic [CW-1:0] I_h_res,
  input  logic [CW-1:0] I_v_total,
  input  logic [CW-1:0] I_v_sync,
  input  logic [CW-1:0] I_v_bporch,
  input  logic [CW-1:0] I_v_res,
  input  logic          I_hs_pol,
  input  logic          I_vs_pol,
  output logic          O_de,
  output logic          O_hs,
  output logic          O_vs,
  output logic          O_sof,
  output logic [DW-1:0] O_data_r,
  output logic [DW-1:0] O_data_g,
  output logic [DW-1:0] O_data_b,
  output logic [7:0]    O_frame_cnt
);

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW:0]   BAR_W = {{CW{1'b0}}, 1'b1} << GL;

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap;
  logic [CW:0]   h_beg, h_end, v_beg, v_end;
  logic          raw_de, raw_hs, raw_vs, at_origin;
  logic [CW-1:0] x_raw, y_raw;

  assign h_wrap    = h_cnt >= I_h_total - ONE;
  assign v_wrap    = v_cnt >= I_v_total - ONE;
  assign h_beg     = {1'b0, I_h_sync} + {1'b0, I_h_bporch};
  assign h_end     = h_beg + {1'b0, I_h_res};
  assign v_beg     = {1'b0, I_v_sync} + {1'b0, I_v_bporch};
  assign v_end     = v_beg + {1'b0, I_v_res};
  assign raw_hs    = h_cnt < I_h_sync;
  assign raw_vs    = v_cnt < I_v_sync;
  assign raw_de    = ({1'b0, h_cnt} >= h_beg) && ({1'b0, h_cnt} < h_end) &&
                     ({1'b0, v_cnt} >= v_beg) && ({1'b0, v_cnt} < v_end);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign x_raw     = h_cnt - I_h_sync - I_h_bporch;
  assign y_raw     = v_cnt - I_v_sync - I_v_bporch;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + ONE;
    end else begin
      h_cnt <= h_cnt + ONE;
    end
  end

  // Colour-bar index tracks the active pixel stream, restarting at every line start.
  logic          s1_de, s1_hs, s1_vs, s1_sof;
  logic [CW-1:0] s1_x, s1_y;
  logic [2:0]    s1_bar;
  logic [CW-1:0] bar_w, bar_cnt, cur_cnt;
  logic [2:0]    bar_idx, cur_idx;
  logic          de_rise;

  assign bar_w   = I_h_res >> 3;
  assign de_rise = raw_de & ~s1_de;
  assign cur_cnt = de_rise ? '0 : bar_cnt;
  assign cur_idx = de_rise ? '0 : bar_idx;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bar_cnt <= '0;
      bar_idx <= '0;
      s1_de   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_sof  <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_bar  <= '0;
    end else begin
      if (raw_de) begin
        if (cur_cnt == bar_w - ONE) begin
          bar_cnt <= '0;
          bar_idx <= (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
        end else begin
          bar_cnt <= cur_cnt + ONE;
          bar_idx <= cur_idx;
        end
      end
      s1_de  <= raw_de;
      s1_hs  <= raw_hs;
      s1_vs  <= raw_vs;
      s1_sof <= at_origin;
      s1_x   <= x_raw;
      s1_y   <= y_raw;
      s1_bar <= cur_idx;
    end
  end

  // Frame-rate state; the first origin after reset is frame 0, so only later ones advance.
  logic [2:0]    mode_q;
  logic [CW-1:0] offset;
  logic [CW:0]   off_next;
  logic          started;

  assign off_next = {1'b0, offset} + (CW+1)'(4);

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mode_q      <= '0;
      offset      <= '0;
      O_frame_cnt <= '0;
      started     <= 1'b0;
    end else if (at_origin) begin
      mode_q  <= I_mode;
      started <= 1'b1;
      if (started) begin
        O_frame_cnt <= O_frame_cnt + 8'd1;
        offset      <= (off_next >= {1'b0, I_h_res}) ? '0 : off_next[CW-1:0];
      end
    end
  end

  logic [DW-1:0] pat_r, pat_g, pat_b;
  logic          grid_hit, bar_hit;
  logic [CW:0]   x_ext, bar_lo;

  assign x_ext    = {1'b0, s1_x};
  assign bar_lo   = {1'b0, offset};
  assign bar_hit  = (x_ext >= bar_lo) && (x_ext < bar_lo + BAR_W);
  assign grid_hit = (s1_x[GL-1:0] == '0) || (s1_y[GL-1:0] == '0) ||
                    (s1_x == I_h_res - ONE) || (s1_y == I_v_res - ONE);

  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (mode_q)
      3'd0: begin
        pat_r = {DW{~s1_bar[1]}};
        pat_g = {DW{~s1_bar[2]}};
        pat_b = {DW{~s1_bar[0]}};
      end
      3'd1: if (grid_hit) pat_r = '1;
      3'd2: begin
        pat_r = s1_x[DW-1:0];
        pat_g = s1_x[DW-1:0];
        pat_b = s1_x[DW-1:0];
      end
      3'd3: begin
        pat_r = I_single_r;
        pat_g = I_single_g;
        pat_b = I_single_b;
      end
      3'd4: if (s1_x[GL] ^ s1_y[GL]) begin
        pat_r = '1;
        pat_g = '1;
        pat_b = '1;
      end
      3'd5: if (bar_hit) begin
        pat_r = '1;
        pat_g = '1;
        pat_b = '1;
      end
      3'd6: begin
        pat_r = s1_y[DW-1:0];
        pat_g = s1_y[DW-1:0];
        pat_b = s1_y[DW-1:0];
      end
      3'd7: case (O_frame_cnt[7:6])
        2'd0: pat_r = '1;
        2'd1: pat_g = '1;
        2'd2: pat_b = '1;
        2'd3: begin
          pat_r = '1;
          pat_g = '1;
          pat_b = '1;
        end
      endcase
    endcase
    if (!s1_de) begin
      pat_r = '0;
      pat_g = '0;
      pat_b = '0;
    end
  end

  logic          s2_de, s2_hs, s2_vs, s2_sof;
  logic [DW-1:0] s2_r, s2_g, s2_b;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s2_de    <= 1'b0;
      s2_hs    <= 1'b0;
      s2_vs    <= 1'b0;
      s2_sof   <= 1'b0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
      O_de     <= 1'b0;
      O_hs     <= 1'b0;
      O_vs     <= 1'b0;
      O_sof    <= 1'b0;
      O_data_r <= '0;
      O_data_g <= '0;
      O_data_b <= '0;
    end else begin
      s2_de    <= s1_de;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      s2_sof   <= s1_sof;
      s2_r     <= pat_r;
      s2_g     <= pat_g;
      s2_b     <= pat_b;
      O_de     <= s2_de;
      O_hs     <= s2_hs ? I_hs_pol : ~I_hs_pol;
      O_vs     <= s2_vs ? I_vs_pol : ~I_vs_pol;
      O_sof    <= s2_sof;
      O_data_r <= s2_r;
      O_data_g <= s2_g;
      O_data_b <= s2_b;
    end
  end

endmodule
